// File: rtl/hazard_forward_unit_if.sv
// Hazard/forwarding bus between the ID stage and hazard_forward_unit.
// Carries the ID-stage instruction fields and flush toward the unit.
// Carries the operand-select codes, stall and stall counter back to the pipeline.
// master: pipeline/ID side. slave: hazard_forward_unit.
interface hazard_forward_unit_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FWD_W  = 6
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_we;
  logic              id_lui;
  logic              id_mem_read;
  logic              flush;
  logic [FWD_W-1:0]  forward_EN1;
  logic [FWD_W-1:0]  forward_EN2;
  logic              stall;
  logic [31:0]       stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_we, id_lui, id_mem_read, flush,
    input  forward_EN1, forward_EN2, stall, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
           id_rd, id_reg_we, id_lui, id_mem_read, flush,
    output forward_EN1, forward_EN2, stall, stall_count
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forwarding and load-use hazard unit for the 5-stage RV32I pipeline.
// It keeps a shadow copy of the EX and MEM destination state.
// It produces the one-hot operand-select codes used by cpuregfile, plus the load-use stall.
// Ports:
//   clk  - pipeline clock, all state updates on posedge
//   rst  - synchronous active-high reset
//   bus  - hazard_forward_unit_if.slave:
//          ID fields and flush in; forward_EN1/2, stall and stall_count out
// forward_EN1/2 and stall are combinational so they settle before the posedge.
// Optional feature: define HAZ_STALL_CNT_EN to enable the saturating stall counter.
// Otherwise stall_count is tied to zero.
module hazard_forward_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned FWD_W  = 6
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_unit_if.slave bus
);

  localparam logic [FWD_W-1:0] FWD_NONE     = '0;
  localparam logic [FWD_W-1:0] FWD_EX_LUI   = FWD_W'(6'b100000);
  localparam logic [FWD_W-1:0] FWD_MEM_LUI  = FWD_W'(6'b010000);
  localparam logic [FWD_W-1:0] FWD_EX_ALU   = FWD_W'(6'b001000);
  localparam logic [FWD_W-1:0] FWD_MEM_ALU  = FWD_W'(6'b000100);
  localparam logic [FWD_W-1:0] FWD_MEM_LD   = FWD_W'(6'b000010);
  localparam logic [FWD_W-1:0] FWD_MEM_LDST = FWD_W'(6'b000001);

  // Shadow EX stage
  logic              ex_valid;
  logic              ex_we;
  logic              ex_lui;
  logic              ex_load;
  logic [REG_AW-1:0] ex_rd;

  // Shadow MEM stage
  logic              mem_valid;
  logic              mem_we;
  logic              mem_lui;
  logic              mem_load;
  logic              mem_stall_seen;
  logic [REG_AW-1:0] mem_rd;

  logic ex_hit1;
  logic ex_hit2;
  logic mem_hit1;
  logic mem_hit2;
  logic load_use1;
  logic load_use2;

  // Source matches a producer stage; x0 and unread sources never match
  function automatic logic src_hit(
    input logic              id_ok,
    input logic              used,
    input logic [REG_AW-1:0] rs,
    input logic              stg_valid,
    input logic              stg_we,
    input logic [REG_AW-1:0] stg_rd
  );
    return id_ok & used & (rs != '0) & stg_valid & stg_we & (stg_rd == rs);
  endfunction

  // Youngest producer wins; an EX load yields no code because the stall covers it
  function automatic logic [FWD_W-1:0] sel_code(
    input logic kill,
    input logic e_hit,
    input logic e_lui,
    input logic e_load,
    input logic m_hit,
    input logic m_lui,
    input logic m_load,
    input logic m_seen
  );
    logic [FWD_W-1:0] code;
    code = FWD_NONE;
    if (kill) begin
      code = FWD_NONE;
    end else if (e_hit) begin
      if (e_lui)        code = FWD_EX_LUI;
      else if (!e_load) code = FWD_EX_ALU;
      else              code = FWD_NONE;
    end else if (m_hit) begin
      if (m_lui)        code = FWD_MEM_LUI;
      else if (m_load)  code = m_seen ? FWD_MEM_LDST : FWD_MEM_LD;
      else              code = FWD_MEM_ALU;
    end
    return code;
  endfunction

  assign ex_hit1  = src_hit(bus.id_valid, bus.id_rs1_used, bus.id_rs1, ex_valid,  ex_we,  ex_rd);
  assign ex_hit2  = src_hit(bus.id_valid, bus.id_rs2_used, bus.id_rs2, ex_valid,  ex_we,  ex_rd);
  assign mem_hit1 = src_hit(bus.id_valid, bus.id_rs1_used, bus.id_rs1, mem_valid, mem_we, mem_rd);
  assign mem_hit2 = src_hit(bus.id_valid, bus.id_rs2_used, bus.id_rs2, mem_valid, mem_we, mem_rd);

  assign load_use1 = ex_hit1 & ex_load;
  assign load_use2 = ex_hit2 & ex_load;

  // Stall is not gated by flush: IF/ID must still hold while EX takes a bubble
  assign bus.stall = load_use1 | load_use2;

  assign bus.forward_EN1 = sel_code(bus.flush, ex_hit1, ex_lui, ex_load,
                                    mem_hit1, mem_lui, mem_load, mem_stall_seen);
  assign bus.forward_EN2 = sel_code(bus.flush, ex_hit2, ex_lui, ex_load,
                                    mem_hit2, mem_lui, mem_load, mem_stall_seen);

  // Shadow pipeline advance: MEM <- EX, EX <- ID (bubble on stall or flush)
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid       <= 1'b0;
      ex_we          <= 1'b0;
      ex_lui         <= 1'b0;
      ex_load        <= 1'b0;
      ex_rd          <= '0;
      mem_valid      <= 1'b0;
      mem_we         <= 1'b0;
      mem_lui        <= 1'b0;
      mem_load       <= 1'b0;
      mem_stall_seen <= 1'b0;
      mem_rd         <= '0;
    end else begin
      mem_valid      <= ex_valid;
      mem_we         <= ex_we;
      mem_lui        <= ex_lui;
      mem_load       <= ex_load;
      mem_rd         <= ex_rd;
      // A stall always means the bubble went in right behind the EX load
      mem_stall_seen <= bus.stall;
      ex_valid       <= bus.id_valid & ~bus.stall & ~bus.flush;
      ex_we          <= bus.id_reg_we;
      ex_lui         <= bus.id_lui;
      ex_load        <= bus.id_mem_read;
      ex_rd          <= bus.id_rd;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (bus.stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`else
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed, table-driven bench for hazard_forward_unit.
// Each table row is one pipeline cycle. Its ID fields are driven and its outputs are checked before the posedge.
// The EX/MEM state a row sees is whatever the previous rows pushed down the pipe.
module tb_hazard_forward_unit;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned FWD_W  = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_forward_unit_if #(.REG_AW(REG_AW), .FWD_W(FWD_W)) bus ();

  hazard_forward_unit #(.REG_AW(REG_AW), .FWD_W(FWD_W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic       rst;
    logic       flush;
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       we;
    logic       lui;
    logic       ld;
    logic [5:0] f1;
    logic [5:0] f2;
    logic       st;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   model_cnt = 0;

  function automatic vec_t mk(input logic r, input logic fl, input logic v,
                              input int rs1, input int rs2, input logic u1, input logic u2,
                              input int rd, input logic we, input logic lui, input logic ld,
                              input logic [5:0] f1, input logic [5:0] f2, input logic st);
    vec_t x;
    x.rst = r; x.flush = fl; x.valid = v;
    x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.u1 = u1; x.u2 = u2;
    x.rd = 5'(rd); x.we = we; x.lui = lui; x.ld = ld;
    x.f1 = f1; x.f2 = f2; x.st = st;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rst             = x.rst;
    bus.flush       = x.flush;
    bus.id_valid    = x.valid;
    bus.id_rs1      = x.rs1;
    bus.id_rs2      = x.rs2;
    bus.id_rs1_used = x.u1;
    bus.id_rs2_used = x.u2;
    bus.id_rd       = x.rd;
    bus.id_reg_we   = x.we;
    bus.id_lui      = x.lui;
    bus.id_mem_read = x.ld;
  endtask

  function automatic logic [31:0] exp_count();
`ifdef HAZ_STALL_CNT_EN
    return 32'(model_cnt);
`else
    return 32'd0;
`endif
  endfunction

  // Check at negedge, then advance one posedge and update the counter model
  task automatic check_and_step(input string tag, input logic [5:0] f1, input logic [5:0] f2,
                                input logic st, input logic r);
    @(negedge clk);
    check({tag, " fwd1"}, 32'(bus.forward_EN1), 32'(f1));
    check({tag, " fwd2"}, 32'(bus.forward_EN2), 32'(f2));
    check({tag, " stall"}, 32'(bus.stall), 32'(st));
    check({tag, " cnt"}, bus.stall_count, exp_count());
    @(posedge clk);
    if (r) model_cnt = 0;
    else if (st) model_cnt++;
    #1;
  endtask

  initial begin
    // Comment after each row: ID instruction / EX, MEM state seen by that row
    vecs.push_back(mk(0,0,0, 0, 0,0,0, 0,0,0,0, 6'b000000,6'b000000,0)); // 0 idle after reset
    vecs.push_back(mk(0,0,1, 1, 0,1,0, 5,1,0,0, 6'b000000,6'b000000,0)); // 1 addi x5,x1
    vecs.push_back(mk(0,0,1, 5, 5,1,1, 6,1,0,0, 6'b001000,6'b001000,0)); // 2 add x6,x5,x5 / EX addi x5
    vecs.push_back(mk(0,0,1, 5, 2,1,1, 9,1,0,0, 6'b000100,6'b000000,0)); // 3 sub x9,x5,x2 / MEM addi x5
    vecs.push_back(mk(0,0,1, 1, 0,1,0, 7,1,0,1, 6'b000000,6'b000000,0)); // 4 lw x7
    vecs.push_back(mk(0,0,1, 7, 0,1,1, 8,1,0,0, 6'b000000,6'b000000,1)); // 5 add x8,x7,x0 / EX lw x7: stall
    vecs.push_back(mk(0,0,1, 7, 0,1,1, 8,1,0,0, 6'b000001,6'b000000,0)); // 6 held / MEM lw x7 after stall
    vecs.push_back(mk(0,0,1, 1, 0,1,0,10,1,0,1, 6'b000000,6'b000000,0)); // 7 lw x10
    vecs.push_back(mk(0,0,1, 3, 0,1,0,11,1,0,0, 6'b000000,6'b000000,0)); // 8 addi x11,x3
    vecs.push_back(mk(0,0,1,10,11,1,1,12,1,0,0, 6'b000010,6'b001000,0)); // 9 add x12,x10,x11
    vecs.push_back(mk(0,0,1, 0, 0,1,0, 3,1,0,0, 6'b000000,6'b000000,0)); // 10 addi x3,x0
    vecs.push_back(mk(0,0,1, 0, 0,0,0, 3,1,1,0, 6'b000000,6'b000000,0)); // 11 lui x3 / EX addi x3
    vecs.push_back(mk(0,0,1, 3, 3,1,1,13,1,0,0, 6'b100000,6'b100000,0)); // 12 add x13,x3,x3 / EX lui, MEM addi
    vecs.push_back(mk(0,0,1, 0, 0,0,0, 3,1,1,0, 6'b000000,6'b000000,0)); // 13 lui x3
    vecs.push_back(mk(0,0,1, 4, 0,1,0, 3,1,0,0, 6'b000000,6'b000000,0)); // 14 addi x3,x4 / EX lui x3
    vecs.push_back(mk(0,0,1, 3, 0,1,1,14,1,0,0, 6'b001000,6'b000000,0)); // 15 add x14,x3,x0 / EX addi, MEM lui
    vecs.push_back(mk(0,0,1, 0, 0,0,0,15,1,1,0, 6'b000000,6'b000000,0)); // 16 lui x15
    vecs.push_back(mk(0,0,1, 2, 0,1,0,16,1,0,0, 6'b000000,6'b000000,0)); // 17 addi x16,x2
    vecs.push_back(mk(0,0,1,15,16,1,1,17,1,0,0, 6'b010000,6'b001000,0)); // 18 add x17,x15,x16
    vecs.push_back(mk(0,0,1, 1, 0,1,0, 0,1,0,0, 6'b000000,6'b000000,0)); // 19 addi x0,x1
    vecs.push_back(mk(0,0,1, 0, 0,1,1,18,1,0,0, 6'b000000,6'b000000,0)); // 20 add x18,x0,x0 / EX writes x0
    vecs.push_back(mk(0,0,1,18,18,1,0,19,1,0,0, 6'b001000,6'b000000,0)); // 21 addi x19,x18 (rs2 unused)
    vecs.push_back(mk(0,0,0,19,19,1,1, 0,0,0,0, 6'b000000,6'b000000,0)); // 22 id_valid=0
    vecs.push_back(mk(0,0,1,19,19,1,1,20,1,0,0, 6'b000100,6'b000100,0)); // 23 add x20,x19,x19 / MEM addi x19
    vecs.push_back(mk(0,0,1, 1, 0,1,0,21,1,0,1, 6'b000000,6'b000000,0)); // 24 lw x21
    vecs.push_back(mk(0,1,1,21,21,1,1,22,1,0,0, 6'b000000,6'b000000,1)); // 25 load-use + flush
    vecs.push_back(mk(0,0,1,21, 2,1,1,23,1,0,0, 6'b000001,6'b000000,0)); // 26 add x23,x21,x2 / MEM lw seen
    vecs.push_back(mk(0,1,1,23,23,1,1,24,1,0,0, 6'b000000,6'b000000,0)); // 27 flushed reader of EX x23
    vecs.push_back(mk(0,0,1,23, 0,1,1,25,1,0,0, 6'b000100,6'b000000,0)); // 28 EX was bubbled, MEM x23
    vecs.push_back(mk(0,0,1, 1, 0,1,0,26,1,0,1, 6'b000000,6'b000000,0)); // 29 lw x26
    vecs.push_back(mk(1,0,1,26, 0,1,1,27,1,0,0, 6'b000000,6'b000000,1)); // 30 stall with rst asserted
    vecs.push_back(mk(0,0,1,26, 0,1,1,27,1,0,0, 6'b000000,6'b000000,0)); // 31 after reset: all clear

    drive(mk(1,0,0, 0,0,0,0, 0,0,0,0, 6'b0,6'b0,0));
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      check_and_step($sformatf("row%0d", i), vecs[i].f1, vecs[i].f2, vecs[i].st, vecs[i].rst);
    end

    // Hand sequence: load-use on rs2 only, then counter and 000001 from MEM
    drive(mk(0,0,1, 1, 0,1,0, 5,1,0,1, 6'b0,6'b0,0));          // lw x5
    check_and_step("seq lw", 6'b000000, 6'b000000, 1'b0, 1'b0);
    drive(mk(0,0,1, 0, 5,1,1, 6,1,0,0, 6'b0,6'b0,0));          // add x6,x0,x5
    check_and_step("seq stall", 6'b000000, 6'b000000, 1'b1, 1'b0);
    check_and_step("seq fwd", 6'b000000, 6'b000001, 1'b0, 1'b0);
    drive(mk(0,0,0, 0, 0,0,0, 0,0,0,0, 6'b0,6'b0,0));
    check_and_step("seq idle", 6'b000000, 6'b000000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
